clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 123 ++++++++++++
 tb/tb_clock_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Hours/minutes/seconds clock with a three-state set mode (RUN -> SET_HR -> SET_MIN).
// Every output is registered; one-cycle latency from the inputs to the outputs.
module clock_ctrl #(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic [1:0] o_mode,
  output logic       o_blank_hr,
  output logic       o_blank_min,
  output logic       o_day_tick
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
  localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);
  localparam logic [4:0] HR_TOP  = 5'(HR_MAX);

  mode_e      state, state_nxt;
  logic [5:0] sec_nxt, min_nxt;
  logic [4:0] hr_nxt;
  logic       blink_q, blink_nxt;
  logic       day_nxt;

  // A ">=" test keeps a field bounded even if it somehow lands above its top.
  logic sec_wrap, min_wrap, hr_wrap;
  assign sec_wrap = (o_sec >= SEC_TOP);
  assign min_wrap = (o_min >= MIN_TOP);
  assign hr_wrap  = (o_hr  >= HR_TOP);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt = state;
    sec_nxt   = o_sec;
    min_nxt   = o_min;
    hr_nxt    = o_hr;
    blink_nxt = blink_q;
    day_nxt   = 1'b0;

    case (state)
      MODE_RUN: begin
        if (i_tick) begin
          if (sec_wrap) begin
            sec_nxt = '0;
            if (min_wrap) begin
              min_nxt = '0;
              if (hr_wrap) begin
                hr_nxt  = '0;
                day_nxt = 1'b1;
              end else begin
                hr_nxt = o_hr + 5'd1;
              end
            end else begin
              min_nxt = o_min + 6'd1;
            end
          end else begin
            sec_nxt = o_sec + 6'd1;
          end
        end
        if (i_btn_mode) state_nxt = MODE_SET_HR;
      end

      MODE_SET_HR: begin
        if (i_btn_mode)     state_nxt = MODE_SET_MIN;
        else if (i_btn_inc) hr_nxt = hr_wrap ? 5'd0 : o_hr + 5'd1;
      end

      MODE_SET_MIN: begin
        if (i_btn_mode) begin
          state_nxt = MODE_RUN;
          sec_nxt   = '0;
        end else if (i_btn_inc) begin
          min_nxt = min_wrap ? 6'd0 : o_min + 6'd1;
        end
      end

      default: state_nxt = MODE_RUN;
    endcase

    // Blink phase restarts on every mode change and only runs inside a set mode.
    if (state_nxt == MODE_RUN || state_nxt != state) blink_nxt = 1'b0;
    else if (i_tick)                                 blink_nxt = ~blink_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= MODE_RUN;
      o_sec       <= '0;
      o_min       <= '0;
      o_hr        <= '0;
      blink_q     <= 1'b0;
      o_blank_hr  <= 1'b0;
      o_blank_min <= 1'b0;
      o_day_tick  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_sec       <= sec_nxt;
      o_min       <= min_nxt;
      o_hr        <= hr_nxt;
      blink_q     <= blink_nxt;
      o_blank_hr  <= (state_nxt == MODE_SET_HR)  && blink_nxt;
      o_blank_min <= (state_nxt == MODE_SET_MIN) && blink_nxt;
      o_day_tick  <= day_nxt;
    end
  end

  assign o_mode = state;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl: run counting, rollover, set modes, blink and async reset.
module tb_clock_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_tick, i_btn_mode, i_btn_inc;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hr;
  logic [1:0] o_mode;
  logic       o_blank_hr, o_blank_min, o_day_tick;

  int total = 0;
  int bad   = 0;

  clock_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_btn_mode (i_btn_mode),
    .i_btn_inc  (i_btn_inc),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hr       (o_hr),
    .o_mode     (o_mode),
    .o_blank_hr (o_blank_hr),
    .o_blank_min(o_blank_min),
    .o_day_tick (o_day_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"},  32'(o_hr),  32'(h));
    check({tag, ".min"}, 32'(o_min), 32'(m));
    check({tag, ".sec"}, 32'(o_sec), 32'(s));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic tick, input logic mode, input logic inc);
    i_tick     = tick;
    i_btn_mode = mode;
    i_btn_inc  = inc;
    @(posedge i_clk);
    #1;
    i_tick     = 1'b0;
    i_btn_mode = 1'b0;
    i_btn_inc  = 1'b0;
  endtask

  initial begin
    i_rst      = 1'b1;
    i_tick     = 1'b0;
    i_btn_mode = 1'b0;
    i_btn_inc  = 1'b0;
    @(posedge i_clk);
    #1;
    check_time("reset", 0, 0, 0);
    check("reset.mode", 32'(o_mode), 0);
    check("reset.blank_hr", 32'(o_blank_hr), 0);
    check("reset.blank_min", 32'(o_blank_min), 0);
    check("reset.day", 32'(o_day_tick), 0);
    i_rst = 1'b0;

    // Sixty ticks in RUN: one minute.
    repeat (59) step(1, 0, 0);
    check_time("run59", 0, 0, 59);
    step(1, 0, 0);
    check_time("run60", 0, 1, 0);
    check("run60.day", 32'(o_day_tick), 0);
    step(0, 0, 1);
    check_time("run_inc_ignored", 0, 1, 0);
    repeat (37) step(1, 0, 0);
    check_time("run97", 0, 1, 37);

    // SET_HR: 25 increments from 0 wrap to 1.
    step(0, 1, 0);
    check("sethr.mode", 32'(o_mode), 1);
    check("sethr.blank_hr", 32'(o_blank_hr), 0);
    repeat (25) step(0, 0, 1);
    check_time("sethr25", 1, 1, 37);

    // Blink in SET_HR: 1,0,1 with time frozen.
    step(1, 0, 0);
    check("blink1.hr", 32'(o_blank_hr), 1);
    check("blink1.min", 32'(o_blank_min), 0);
    step(1, 0, 0);
    check("blink2.hr", 32'(o_blank_hr), 0);
    check("blink2.min", 32'(o_blank_min), 0);
    step(1, 0, 0);
    check("blink3.hr", 32'(o_blank_hr), 1);
    check("blink3.min", 32'(o_blank_min), 0);
    check_time("blink_frozen", 1, 1, 37);

    // Mode and inc together: mode wins.
    step(0, 1, 1);
    check("modeinc.mode", 32'(o_mode), 2);
    check_time("modeinc", 1, 1, 37);
    check("modeinc.blank_hr", 32'(o_blank_hr), 0);
    check("modeinc.blank_min", 32'(o_blank_min), 0);

    // SET_MIN: 59 wraps to 0 with no carry into hours.
    repeat (58) step(0, 0, 1);
    check_time("setmin59", 1, 59, 37);
    step(0, 0, 1);
    check_time("setmin_wrap", 1, 0, 37);
    repeat (59) step(0, 0, 1);
    check_time("setmin_back59", 1, 59, 37);

    // Leaving SET_MIN clears seconds.
    step(0, 1, 0);
    check("exit.mode", 32'(o_mode), 0);
    check_time("exit", 1, 59, 0);

    // Preload 23:59:00, then count up to the day rollover.
    step(0, 1, 0);
    repeat (22) step(0, 0, 1);
    check_time("sethr23", 23, 59, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("preload.mode", 32'(o_mode), 0);
    repeat (59) step(1, 0, 0);
    check_time("pre_roll", 23, 59, 59);
    check("pre_roll.day", 32'(o_day_tick), 0);
    step(1, 0, 0);
    check_time("roll", 0, 0, 0);
    check("roll.day", 32'(o_day_tick), 1);
    step(0, 0, 0);
    check("post_roll.day", 32'(o_day_tick), 0);

    // Tick and mode together in RUN: both take effect.
    step(1, 1, 0);
    check("tickmode.mode", 32'(o_mode), 1);
    check_time("tickmode", 0, 0, 1);
    step(1, 0, 0);
    check_time("sethr_tick_frozen", 0, 0, 1);

    // Build 12:34:56 in SET_MIN with blink active, then assert reset mid-cycle.
    repeat (12) step(0, 0, 1);
    step(0, 1, 0);
    repeat (34) step(0, 0, 1);
    step(0, 1, 0);
    repeat (56) step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check_time("prereset", 12, 34, 56);
    check("prereset.mode", 32'(o_mode), 2);
    check("prereset.blank_min", 32'(o_blank_min), 1);
    #2;
    i_rst = 1'b1;
    #1;
    check_time("async_rst", 0, 0, 0);
    check("async_rst.mode", 32'(o_mode), 0);
    check("async_rst.blank_hr", 32'(o_blank_hr), 0);
    check("async_rst.blank_min", 32'(o_blank_min), 0);
    check("async_rst.day", 32'(o_day_tick), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step(1, 0, 0);
    check_time("post_rst", 0, 0, 1);
    check("post_rst.mode", 32'(o_mode), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
